// File: rtl/instr_fetch_decode_if.sv
// Instruction-memory read bus between the fetch unit and instruction memory.
//   imemReq  : read request (driven by the fetch unit)
//   imemAddr : byte address of the requested word (driven by the fetch unit)
//   imemAck  : read data valid (driven by memory)
//   imemData : instruction word, valid while imemAck=1 (driven by memory)
interface instr_fetch_decode_if;
  localparam int unsigned XLEN = 32;

  logic            imemReq;
  logic [XLEN-1:0] imemAddr;
  logic            imemAck;
  logic [XLEN-1:0] imemData;

  modport master (output imemReq, output imemAddr, input imemAck, input imemData);
  modport slave  (input imemReq, input imemAddr, output imemAck, output imemData);
endinterface

// File: rtl/instr_fetch_decode.sv
// Instruction fetch and branch-class decode for the multicycle LEGv8 core.
// Fetches the word at PC over a req/ack bus, latches it, and decodes B / CBZ
// into the PC unit's branch-control inputs.
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   fetchStart, PC          : fetch request and byte address (sampled in IDLE)
//   imem (master)           : instruction-memory req/ack bus
//   busy                    : unit not in IDLE
//   decodeValid, fetchError : one-cycle completion / error pulses
//   instruction, rtField    : latched instruction word and its Rt field
//   branchFlag, unconditionalBranchFlag, pcOffsetFilled : decoded branch info
module instr_fetch_decode #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        fetchStart,
  input  logic [31:0]                 PC,
  instr_fetch_decode_if.master        imem,
  output logic                        busy,
  output logic                        decodeValid,
  output logic                        fetchError,
  output logic [31:0]                 instruction,
  output logic [4:0]                  rtField,
  output logic                        branchFlag,
  output logic                        unconditionalBranchFlag,
  output logic [31:0]                 pcOffsetFilled
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;

  localparam logic [5:0] OPC_B   = 6'b000101;
  localparam logic [7:0] OPC_CBZ = 8'b10110100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DECODE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               req_q, req_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [XLEN-1:0]    instr_q, instr_d;
  logic               br_q, br_d;
  logic               ubr_q, ubr_d;
  logic [XLEN-1:0]    off_q, off_d;

  logic               aligned_c;
  logic               timeout_c;
  logic               is_b_c;
  logic               is_cbz_c;
  logic [XLEN-1:0]    off_c;

  assign aligned_c = (PC[1:0] == 2'b00);
  // Counter equal to the limit means the request has already been up for
  // TIMEOUT_CYCLES+1 cycles, so this is the last cycle it may be answered.
  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Branch-class decode of the latched word; offsets are word counts.
  always_comb begin
    is_b_c   = (instr_q[31:26] == OPC_B);
    is_cbz_c = (instr_q[31:24] == OPC_CBZ);
    off_c    = '0;
    if (is_b_c) begin
      off_c = {{6{instr_q[25]}}, instr_q[25:0]};
    end else if (is_cbz_c) begin
      off_c = {{13{instr_q[23]}}, instr_q[23:5]};
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ack wins over a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fetchStart && aligned_c) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem.imemAck)   state_d = ST_DECODE;
        else if (timeout_c) state_d = ST_IDLE;
      end
      ST_DECODE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    req_d   = req_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    br_d    = br_q;
    ubr_d   = ubr_q;
    off_d   = off_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (fetchStart) begin
          if (aligned_c) begin
            addr_d = PC;
            req_d  = 1'b1;
            cnt_d  = '0;
          end else begin
            err_d   = 1'b1;
            instr_d = '0;
            br_d    = 1'b0;
            ubr_d   = 1'b0;
            off_d   = '0;
          end
        end
      end
      ST_WAIT: begin
        if (imem.imemAck) begin
          instr_d = imem.imemData;
          req_d   = 1'b0;
        end else if (timeout_c) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          instr_d = '0;
          br_d    = 1'b0;
          ubr_d   = 1'b0;
          off_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DECODE: begin
        br_d    = is_cbz_c;
        ubr_d   = is_b_c;
        off_d   = off_c;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      instr_q <= '0;
      br_q    <= 1'b0;
      ubr_q   <= 1'b0;
      off_q   <= '0;
    end else begin
      req_q   <= req_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      instr_q <= instr_d;
      br_q    <= br_d;
      ubr_q   <= ubr_d;
      off_q   <= off_d;
    end
  end

  assign imem.imemReq            = req_q;
  assign imem.imemAddr           = addr_q;
  assign busy                    = busy_q;
  assign decodeValid             = valid_q;
  assign fetchError              = err_q;
  assign instruction             = instr_q;
  assign rtField                 = instr_q[4:0];
  assign branchFlag              = br_q;
  assign unconditionalBranchFlag = ubr_q;
  assign pcOffsetFilled          = off_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode: directed cases followed by
// randomized fetches compared against a behavioural model of the decode rules.
module tb_instr_fetch_decode;
  localparam int unsigned T = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetchStart = 1'b0;
  logic [31:0] PC = '0;
  logic        busy, decodeValid, fetchError;
  logic [31:0] instruction;
  logic [4:0]  rtField;
  logic        branchFlag, unconditionalBranchFlag;
  logic [31:0] pcOffsetFilled;

  instr_fetch_decode_if bus();

  instr_fetch_decode #(.TIMEOUT_CYCLES(T)) dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .fetchStart              (fetchStart),
    .PC                      (PC),
    .imem                    (bus),
    .busy                    (busy),
    .decodeValid             (decodeValid),
    .fetchError              (fetchError),
    .instruction             (instruction),
    .rtField                 (rtField),
    .branchFlag              (branchFlag),
    .unconditionalBranchFlag (unconditionalBranchFlag),
    .pcOffsetFilled          (pcOffsetFilled)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: what the decoded outputs should currently hold.
  logic [31:0] exp_instr = '0;
  logic        exp_b = 1'b0;
  logic        exp_cbz = 1'b0;
  logic [31:0] exp_off = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".instr"}, instruction, exp_instr);
    chk({tag, ".rt"}, 32'(rtField), exp_instr % 32);
    chk({tag, ".ubr"}, 32'(unconditionalBranchFlag), 32'(exp_b));
    chk({tag, ".br"}, 32'(branchFlag), 32'(exp_cbz));
    chk({tag, ".off"}, pcOffsetFilled, exp_off);
  endtask

  task automatic model_nop();
    exp_instr = '0; exp_b = 1'b0; exp_cbz = 1'b0; exp_off = '0;
  endtask

  // Decode rules as plain arithmetic on the instruction value.
  task automatic model_decode(input logic [31:0] w);
    longint imm;
    exp_instr = w;
    exp_b     = ((w >> 26) == 32'd5);
    exp_cbz   = ((w >> 24) == 32'd180);
    exp_off   = '0;
    if (exp_b) begin
      imm = longint'(w % (32'd1 << 26));
      if (imm >= (64'sd1 << 25)) imm = imm - (64'sd1 << 26);
      exp_off = 32'(imm);
    end else if (exp_cbz) begin
      imm = longint'((w >> 5) % (32'd1 << 19));
      if (imm >= (64'sd1 << 18)) imm = imm - (64'sd1 << 19);
      exp_off = 32'(imm);
    end
  endtask

  // One fetch; delay = idle WAIT cycles before ack (delay > T means no ack).
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data, input int delay);
    int  start_cyc;
    int  high;
    logic acked;
    @(negedge clock);
    fetchStart = 1'b1;
    PC = pc;
    start_cyc = cyc;
    @(negedge clock);
    fetchStart = 1'b0;
    PC = $urandom;
    if (pc[1:0] != 2'b00) begin
      model_nop();
      chk("mis.err", 32'(fetchError), 32'd1);
      chk("mis.req", 32'(bus.imemReq), 32'd0);
      chk("mis.valid", 32'(decodeValid), 32'd0);
      chk("mis.busy", 32'(busy), 32'd0);
      chk_outs("mis");
      @(negedge clock);
      chk("mis.err_clr", 32'(fetchError), 32'd0);
      chk("mis.req_low", 32'(bus.imemReq), 32'd0);
      return;
    end
    chk("req.addr", bus.imemAddr, pc);
    chk("req.busy", 32'(busy), 32'd1);
    high  = 0;
    acked = 1'b0;
    for (int k = 0; k <= int'(T); k++) begin
      chk("wait.req", 32'(bus.imemReq), 32'd1);
      chk("wait.valid", 32'(decodeValid), 32'd0);
      high++;
      fetchStart = 1'($urandom_range(0, 1));
      PC = $urandom;
      if (k == delay) begin
        bus.imemAck  = 1'b1;
        bus.imemData = data;
        acked = 1'b1;
      end else begin
        bus.imemAck  = 1'b0;
        bus.imemData = $urandom;
      end
      @(negedge clock);
      bus.imemAck = 1'b0;
      if (acked) break;
    end
    if (acked) begin
      chk("dec.req", 32'(bus.imemReq), 32'd0);
      chk("dec.busy", 32'(busy), 32'd1);
      chk("dec.valid", 32'(decodeValid), 32'd0);
      chk("dec.err", 32'(fetchError), 32'd0);
      model_decode(data);
      @(negedge clock);
      fetchStart = 1'b0;
      chk("done.valid", 32'(decodeValid), 32'd1);
      chk("done.busy", 32'(busy), 32'd0);
      chk("done.err", 32'(fetchError), 32'd0);
      chk("done.latency", 32'(cyc - start_cyc - 1), 32'(delay + 2));
      chk_outs("done");
      @(negedge clock);
      chk("done.valid_clr", 32'(decodeValid), 32'd0);
    end else begin
      fetchStart = 1'b0;
      model_nop();
      chk("to.req_high", 32'(high), 32'(T + 1));
      chk("to.req", 32'(bus.imemReq), 32'd0);
      chk("to.err", 32'(fetchError), 32'd1);
      chk("to.busy", 32'(busy), 32'd0);
      chk("to.valid", 32'(decodeValid), 32'd0);
      chk_outs("to");
      @(negedge clock);
      chk("to.err_clr", 32'(fetchError), 32'd0);
    end
  endtask

  // Idle cycles with stray acks that must be ignored.
  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      bus.imemAck  = 1'($urandom_range(0, 1));
      bus.imemData = $urandom;
      chk("idle.valid", 32'(decodeValid), 32'd0);
      chk("idle.busy", 32'(busy), 32'd0);
      chk("idle.req", 32'(bus.imemReq), 32'd0);
    end
    @(negedge clock);
    bus.imemAck = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pc, data;
    int          sel;
    bus.imemAck  = 1'b0;
    bus.imemData = '0;

    // Reset state.
    #2;
    chk("rst.req", 32'(bus.imemReq), 32'd0);
    chk("rst.addr", bus.imemAddr, 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.valid", 32'(decodeValid), 32'd0);
    chk("rst.err", 32'(fetchError), 32'd0);
    chk_outs("rst");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // B, one wait cycle.
    do_fetch(32'h40, 32'h17FF_FFFD, 1);
    chk("B.ubr_const", 32'(unconditionalBranchFlag), 32'd1);
    chk("B.br_const", 32'(branchFlag), 32'd0);
    chk("B.off_const", pcOffsetFilled, 32'hFFFF_FFFD);

    // CBZ, immediate ack.
    do_fetch(32'h44, 32'hB400_0103, 0);
    chk("CBZ.br_const", 32'(branchFlag), 32'd1);
    chk("CBZ.off_const", pcOffsetFilled, 32'h0000_0008);
    chk("CBZ.rt_const", 32'(rtField), 32'd3);

    // ADD, no branch.
    do_fetch(32'h48, 32'h8B02_0020, 0);
    chk("ADD.instr_const", instruction, 32'h8B02_0020);
    chk("ADD.off_const", pcOffsetFilled, 32'd0);
    chk("ADD.rt_const", 32'(rtField), 32'd0);

    // Ack exactly on the timeout cycle still succeeds.
    do_fetch(32'h4C, 32'h1400_0010, int'(T));

    // Timeout, then the next fetch is accepted.
    do_fetch(32'h50, 32'h0, 99);
    do_fetch(32'h54, 32'hB4FF_FFE1, 2);

    // Misaligned PC.
    do_fetch(32'h06, 32'h0, 0);
    idle_noise(3);

    // Reset asserted mid-WAIT.
    @(negedge clock);
    fetchStart = 1'b1;
    PC = 32'h100;
    @(negedge clock);
    fetchStart = 1'b0;
    chk("rw.req_before", 32'(bus.imemReq), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    model_nop();
    chk("rw.req", 32'(bus.imemReq), 32'd0);
    chk("rw.addr", bus.imemAddr, 32'd0);
    chk("rw.busy", 32'(busy), 32'd0);
    chk("rw.valid", 32'(decodeValid), 32'd0);
    chk("rw.err", 32'(fetchError), 32'd0);
    chk_outs("rw");
    @(negedge clock);
    reset_n = 1'b1;
    bus.imemAck  = 1'b1;
    bus.imemData = 32'h17FF_FFFD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rw.late_ack_valid", 32'(decodeValid), 32'd0);
      chk("rw.late_ack_busy", 32'(busy), 32'd0);
    end
    bus.imemAck = 1'b0;
    do_fetch(32'h104, 32'hB400_0103, 1);

    // Randomized fetches.
    for (int n = 0; n < 40; n++) begin
      pc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      sel = int'($urandom_range(0, 2));
      if (sel == 0)      data = {6'b000101, 26'($urandom)};
      else if (sel == 1) data = {8'hB4, 24'($urandom)};
      else               data = $urandom;
      do_fetch(pc, data, int'($urandom_range(0, T + 1)));
      if ($urandom_range(0, 2) == 0) idle_noise(int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
